up_down_counter_4: RTL and testbench



---
 rtl/up_down_counter_4.sv | 17 +
 tb/tb_up_down_counter_4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/up_down_counter_4.sv
// up_down_counter_4: free-running up/down counter, modulo 2^WIDTH, async active-high reset
module up_down_counter_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] counter
);
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  always_comb w_next = up_down ? r_count + 1'b1 : r_count - 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else r_count <= w_next;
  assign counter = r_count;
endmodule

// File: tb/tb_up_down_counter_4.sv
// tb_up_down_counter_4: directed checks of reset, both count directions, wrap and async reset
module tb_up_down_counter_4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_down = 1'b0;
  logic [3:0] counter;
  int n_cmp = 0;
  int n_fail = 0;

  up_down_counter_4 dut (.clk(clk), .reset(reset), .up_down(up_down), .counter(counter));

  // rising edges at 5, 15, 25, ... ns
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk) #1;
      n_cmp++;
      if (counter !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %0d expected 0", i, counter);
      end
    end
    #4 reset = 1'b0;
  endtask

  task automatic test_down();
    logic [3:0] exp;
    for (int i = 1; i <= 20; i++) begin
      exp = 4'(16 - (i % 16));
      @(posedge clk) #1;
      n_cmp++;
      if (counter !== exp) begin
        n_fail++;
        $display("FAIL down[%0d]: got %0d expected %0d", i, counter, exp);
      end
    end
    n_cmp++;
    if (counter !== 4'd12) begin
      n_fail++;
      $display("FAIL down_final: got %0d expected 12", counter);
    end
  endtask

  task automatic test_up();
    logic [3:0] exp;
    #4 up_down = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      exp = 4'((12 + i) % 16);
      @(posedge clk);
      #2 up_down = 1'b0;
      #2 up_down = 1'b1;
      n_cmp++;
      if (counter !== exp) begin
        n_fail++;
        $display("FAIL up[%0d]: got %0d expected %0d", i, counter, exp);
      end
    end
    n_cmp++;
    if (counter !== 4'd5) begin
      n_fail++;
      $display("FAIL up_final: got %0d expected 5", counter);
    end
  endtask

  task automatic test_reversal();
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (counter !== 4'd0) begin
      n_fail++;
      $display("FAIL rev_start: got %0d expected 0", counter);
    end
    #3 up_down = 1'b0;
    @(posedge clk) #1;
    n_cmp++;
    if (counter !== 4'd15) begin
      n_fail++;
      $display("FAIL rev_down: got %0d expected 15", counter);
    end
    #3 up_down = 1'b1;
    @(posedge clk) #1;
    n_cmp++;
    if (counter !== 4'd0) begin
      n_fail++;
      $display("FAIL rev_up: got %0d expected 0", counter);
    end
  endtask

  task automatic test_async_reset();
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (counter !== 4'd9) begin
      n_fail++;
      $display("FAIL async_pre: got %0d expected 9", counter);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (counter !== 4'd0) begin
      n_fail++;
      $display("FAIL async_clear: got %0d expected 0", counter);
    end
    @(posedge clk) #1;
    n_cmp++;
    if (counter !== 4'd0) begin
      n_fail++;
      $display("FAIL async_hold: got %0d expected 0", counter);
    end
    #3 reset = 1'b0;
    @(posedge clk) #1;
    n_cmp++;
    if (counter !== 4'd1) begin
      n_fail++;
      $display("FAIL async_resume: got %0d expected 1", counter);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seen;
    logic [3:0] exp;
    seen = '0;
    for (int i = 1; i <= 16; i++) begin
      exp = 4'((1 + i) % 16);
      @(posedge clk) #1;
      seen[counter] = 1'b1;
      n_cmp++;
      if (counter !== exp) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %0d expected %0d", i, counter, exp);
      end
    end
    n_cmp++;
    if (seen !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_codes: got %h expected ffff", seen);
    end
  endtask

  initial begin
    test_reset();
    test_down();
    test_up();
    test_reversal();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
